neosd_rsp_rx: RTL
=================

# neosd_rsp_rx

Receiver for SD card command responses on the CMD line. Armed by the command sequencer after a command has been shifted out. It then does the following:
- waits for the response start bit within the NCR window;
- shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame;
- checks the transmission bit, end bit and CRC7;
- presents the payload with status flags to the host register file.

## Interface
Parameters:
- TIMEOUT, 64, maximum number of sampled high bits before a start bit (NCR limit); range 1..255.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  SD clock sample strobe; the CMD line is sampled only when 1
- sd_cmd_i  in  1  CMD line, already synchronized
- start_i  in  1  arm the receiver; accepted only in IDLE
- long_i  in  1  captured with start_i: 1 = 136-bit R2, 0 = 48-bit
- nocrc_i  in  1  captured with start_i: 1 = skip CRC check (R3)
- abort_i  in  1  return to IDLE immediately; no done_o
- busy_o  out  1  1 in any state other than IDLE
- done_o  out  1  one-clk_i pulse on completion or timeout
- rsp_o  out  128  response payload
- timeout_o  out  1  no start bit within TIMEOUT samples
- crc_err_o  out  1  CRC7 mismatch
- frame_err_o  out  1  transmission bit ≠ 0 or end bit ≠ 1

Reset values: all outputs 0; state IDLE.

## Operation
States and transitions:
- IDLE: start_i=1 → WAIT.
  - On the same edge: latch long_i and nocrc_i; clear rsp_o, all flags, the bit counter, the timeout counter and the CRC register.
- WAIT: on each en_i sample:
  - sd_cmd_i=0 (start bit) → RECV.
  - sd_cmd_i=1 → increment the timeout counter; on the TIMEOUT-th high sample, set timeout_o and go to DONE.
- RECV: consume one bit per en_i sample.
  - Short frame: 47 bits after the start bit (tx, 6 index, 32 arg, 7 CRC, end).
  - Long frame: 135 bits after the start bit.
  - After the end bit is sampled → DONE.
- DONE: assert done_o for one clk_i cycle, then → IDLE.

Field rules:
- Transmission bit (first bit after start) must be 0, otherwise frame_err_o.
- End bit must be 1, otherwise frame_err_o.
- Short frame payload: rsp_o[37:32] = index, rsp_o[31:0] = argument, rsp_o[127:38] = 0.
- Long frame payload: rsp_o[127:1] = R2 bits 127:1 (CID/CSD including its internal CRC), rsp_o[0] = 0.
  - The 6 reserved bits after the tx bit are discarded and not checked.
- CRC7 (x^7+x^3+1, initial value 0):
  - Short frame: over start, tx, index and arg (40 bits).
  - Long frame: over R2 bits 127:8 (120 bits).
  - The result is compared against the 7 received CRC bits.
  - nocrc_i=1 → crc_err_o stays 0.
- rsp_o and the flags hold from DONE until the next accepted start_i.
  - rsp_o contents while busy_o=1 are not meaningful.

Boundary conditions:
- start_i while busy_o=1: ignored.
- abort_i in any non-IDLE state: → IDLE on the next edge.
  - No done_o; flags and rsp_o keep their partial values.
  - abort_i has priority over all other state transitions.
- rst_i has priority over abort_i and start_i.
- en_i=0: state and counters frozen (except the DONE→IDLE step, which is clk_i-driven).
- Timeout takes effect in WAIT only; once in RECV there is no timeout.

## Timing
- start_i sampled at edge N → busy_o=1 from N+1.
- Start bit sampled at en_i edge S.
  - Short frame: last bit sampled at the 47th subsequent en_i edge E.
  - Long frame: last bit sampled at the 135th subsequent en_i edge E.
- Edge E: state → DONE; rsp_o and flags final.
- Edge E+1 (clk_i): done_o=1 for one cycle, busy_o=0 from E+2.
- Timeout: the TIMEOUT-th high sample has the same role as E.
- A start bit on high-sample number ≤ TIMEOUT is accepted; a start bit later than that is never seen.
- With en_i tied to 1, a short frame completes 49 clk_i cycles after the start bit is presented.

## Configuration
- NEOSD_RSP_CRC_EN defined: CRC7 generator and comparator are built, as described above.
- NEOSD_RSP_CRC_EN undefined: no CRC logic is built.
  - crc_err_o is constant 0.
  - The CRC bits are still consumed but discarded.
  - Frame length and timing are unchanged.

## Test plan
- Short R1 frame, index 0x11, arg 0x00000900, correct CRC7 from the model, en_i every 4th clk → rsp_o[37:0] = {6'h11, 32'h00000900}, done_o one pulse, all flags 0.
- Long R2 frame, CID pattern 0x035344534430 3280…, correct internal CRC → rsp_o[127:1] matches the model, crc_err_o=0; then flip one payload bit → crc_err_o=1.
- CMD held high, TIMEOUT=64 → timeout_o=1 and done_o at the 64th sample; a repeat with the start bit at sample 64 is accepted with no timeout.
- Short frame with the end bit forced to 0 → frame_err_o=1; short frame with nocrc_i=1 and a bad CRC → crc_err_o=0.
- abort_i mid-RECV after 20 bits → busy_o=0 next cycle, no done_o; a new start_i is accepted immediately.
- rst_i asserted mid-frame → all outputs 0 next edge; start_i during busy ignored (latched long_i unchanged).

Source files
------------

// File: rtl/neosd_rsp_rx.sv
// neosd_rsp_rx: receives an SD card command response from the CMD line.
// Once armed, it waits up to TIMEOUT sampled high bits for the start bit.
// It then shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame and checks
// the transmission bit, the end bit and (optionally) CRC7.
//
// Optional feature: define NEOSD_RSP_CRC_EN to build the CRC7 generator and
// comparator. When it is undefined, crc_err_o is constant 0 and the received
// CRC bits are consumed but discarded.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active-high
//   en_i        SD clock sample strobe; CMD is sampled only when 1
//   sd_cmd_i    CMD line (already synchronized)
//   start_i     arm the receiver (accepted only when idle)
//   long_i      with start_i: 1 = 136-bit R2, 0 = 48-bit frame
//   nocrc_i     with start_i: 1 = skip CRC check
//   abort_i     return to idle immediately, no done_o
//   busy_o      receiver active
//   done_o      one-cycle completion/timeout pulse
//   rsp_o       response payload
//   timeout_o   no start bit within TIMEOUT samples
//   crc_err_o   CRC7 mismatch
//   frame_err_o transmission bit != 0 or end bit != 1
module neosd_rsp_rx #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         sd_cmd_i,
   input  logic         start_i,
   input  logic         long_i,
   input  logic         nocrc_i,
   input  logic         abort_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [127:0] rsp_o,
   output logic         timeout_o,
   output logic         crc_err_o,
   output logic         frame_err_o
);

   localparam int unsigned CNT_W = 8;
   // bit counter values, counted from 0 = transmission bit
   localparam logic [CNT_W-1:0] SHORT_DATA_LAST = CNT_W'(38);
   localparam logic [CNT_W-1:0] SHORT_LAST      = CNT_W'(46);
   localparam logic [CNT_W-1:0] LONG_DATA_FIRST = CNT_W'(7);
   localparam logic [CNT_W-1:0] LONG_LAST       = CNT_W'(134);
   localparam logic [CNT_W-1:0] TO_LAST         = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RECV,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] bcnt;
   logic [CNT_W-1:0] tcnt;
   logic             long_q;

   logic             start_acc;
   logic             done_nxt;
   logic             wait_hi;
   logic             recv;
   logic             last_bit;
   logic             rsp_sh;

   // next-state logic and per-sample decode
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      done_nxt  = 1'b0;
      wait_hi   = 1'b0;
      recv      = 1'b0;
      last_bit  = 1'b0;
      rsp_sh    = 1'b0;

      // a start during the trailing done cycle (busy_o still high) is ignored
      start_acc = (state == S_IDLE) && start_i && !busy_o;
      done_nxt  = (state == S_DONE) && !abort_i;
      wait_hi   = (state == S_WAIT) && en_i && sd_cmd_i && !abort_i;
      recv      = (state == S_RECV) && en_i && !abort_i;
      last_bit  = (bcnt == (long_q ? LONG_LAST : SHORT_LAST));
      // long frames also shift on the end bit (a 0) to land R2[127:1] at rsp_o[127:1]
      rsp_sh    = long_q ? (bcnt >= LONG_DATA_FIRST)
                         : ((bcnt != '0) && (bcnt <= SHORT_DATA_LAST));

      unique case (state)
         S_IDLE: if (start_acc) state_nxt = S_WAIT;
         S_WAIT: begin
            if (en_i) begin
               if (!sd_cmd_i)          state_nxt = S_RECV;
               else if (tcnt == TO_LAST) state_nxt = S_DONE;
            end
         end
         S_RECV: if (en_i && last_bit) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      if (abort_i && (state != S_IDLE)) state_nxt = S_IDLE;
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // counters, payload shift register and status flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         rsp_o       <= '0;
         timeout_o   <= 1'b0;
         frame_err_o <= 1'b0;
         bcnt        <= '0;
         tcnt        <= '0;
         long_q      <= 1'b0;
      end else begin
         busy_o <= (state_nxt != S_IDLE) || done_nxt;
         done_o <= done_nxt;
         if (start_acc) begin
            long_q      <= long_i;
            rsp_o       <= '0;
            timeout_o   <= 1'b0;
            frame_err_o <= 1'b0;
            bcnt        <= '0;
            tcnt        <= '0;
         end
         if (wait_hi) begin
            tcnt <= tcnt + CNT_W'(1);
            if (tcnt == TO_LAST) timeout_o <= 1'b1;
         end
         if (recv) begin
            bcnt <= bcnt + CNT_W'(1);
            if ((bcnt == '0) && sd_cmd_i) frame_err_o <= 1'b1;
            if (last_bit && !sd_cmd_i)    frame_err_o <= 1'b1;
            if (rsp_sh) rsp_o <= {rsp_o[126:0], sd_cmd_i & ~last_bit};
         end
      end
   end

`ifdef NEOSD_RSP_CRC_EN
   localparam logic [CNT_W-1:0] SHORT_CRC_FIRST = CNT_W'(39);
   localparam logic [CNT_W-1:0] SHORT_CRC_LAST  = CNT_W'(45);
   localparam logic [CNT_W-1:0] LONG_CRC_IN_END = CNT_W'(126);
   localparam logic [CNT_W-1:0] LONG_CRC_FIRST  = CNT_W'(127);
   localparam logic [CNT_W-1:0] LONG_CRC_LAST   = CNT_W'(133);

   logic [6:0] crc_q;
   logic [6:0] crx_q;
   logic       nocrc_q;
   logic       crc_in;
   logic       crx_sh;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   // which received bits feed the generator and which form the received CRC;
   // the start bit is always 0 and the CRC starts at 0, so it is not fed
   always_comb begin
      crc_in = 1'b0;
      crx_sh = 1'b0;
      if (long_q) begin
         crc_in = (bcnt >= LONG_DATA_FIRST) && (bcnt <= LONG_CRC_IN_END);
         crx_sh = (bcnt >= LONG_CRC_FIRST) && (bcnt <= LONG_CRC_LAST);
      end else begin
         crc_in = (bcnt <= SHORT_DATA_LAST);
         crx_sh = (bcnt >= SHORT_CRC_FIRST) && (bcnt <= SHORT_CRC_LAST);
      end
   end

   // CRC7 generator and comparison on the end bit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_q     <= '0;
         crx_q     <= '0;
         nocrc_q   <= 1'b0;
         crc_err_o <= 1'b0;
      end else if (start_acc) begin
         crc_q     <= '0;
         crx_q     <= '0;
         nocrc_q   <= nocrc_i;
         crc_err_o <= 1'b0;
      end else if (recv) begin
         if (crc_in) crc_q <= crc7_step(crc_q, sd_cmd_i);
         if (crx_sh) crx_q <= {crx_q[5:0], sd_cmd_i};
         if (last_bit && !nocrc_q && (crc_q != crx_q)) crc_err_o <= 1'b1;
      end
   end
`else
   logic unused_nocrc;
   assign unused_nocrc = nocrc_i;
   assign crc_err_o    = 1'b0;
`endif

endmodule
